// File: rtl/b_resp_pkg.sv
// Shared types and the response-merge helper for the write-response return path.
package b_resp_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } resp_t;

   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } state_t;

   // Lowest-ranked code, so merging it with any response leaves that response unchanged.
   localparam resp_t ACC_NEUTRAL = EXOKAY;

   // Severity rank: DECERR > SLVERR > OKAY > EXOKAY.
   function automatic logic [1:0] resp_rank(input resp_t r);
      case (r)
         DECERR:  return 2'd3;
         SLVERR:  return 2'd2;
         OKAY:    return 2'd1;
         default: return 2'd0;
      endcase
   endfunction

   // Keep whichever of the two responses is more severe.
   function automatic resp_t resp_merge(input resp_t a, input resp_t b);
      return (resp_rank(a) >= resp_rank(b)) ? a : b;
   endfunction

endpackage

// File: rtl/resp_id_fifo.sv
// Synchronous FIFO of {master, split} entries recording completed write bursts.
module resp_id_fifo #(
   parameter int Depth   = 4,
   parameter int ID_Size = 1
) (
   input  logic               ACLK,
   input  logic               ARESETN,
   input  logic               push,
   input  logic [ID_Size-1:0] push_master,
   input  logic               push_split,
   input  logic               pop,
   output logic [ID_Size-1:0] head_master,
   output logic               head_split,
   output logic               full,
   output logic               empty,
   output logic               overflow
);

   localparam int AW = $clog2(Depth);

   logic [AW:0]        wr_ptr;
   logic [AW:0]        rd_ptr;
   logic [ID_Size-1:0] master_mem [Depth];
   logic               split_mem  [Depth];
   logic               do_push;
   logic               do_pop;

   assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty       = (wr_ptr == rd_ptr);
   assign do_push     = push && !full;
   assign do_pop      = pop && !empty;
   assign head_master = master_mem[rd_ptr[AW-1:0]];
   assign head_split  = split_mem[rd_ptr[AW-1:0]];

   // Pointer advance and sticky overflow; a push while full is dropped even if a pop happens too.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && full) overflow <= 1'b1;
      end
   end

   // Entry storage; contents are only meaningful between the pointers, so no reset is needed.
   always_ff @(posedge ACLK) begin
      if (do_push) begin
         master_mem[wr_ptr[AW-1:0]] <= push_master;
         split_mem[wr_ptr[AW-1:0]]  <= push_split;
      end
   end

endmodule

// File: rtl/b_resp_router.sv
// Steers slave B responses back to the originating masters in issue order, merging split bursts.
module b_resp_router
   import b_resp_pkg::*;
#(
   parameter int Masters_Num = 2,
   parameter int ID_Size     = (Masters_Num > 1) ? $clog2(Masters_Num) : 1,
   parameter int Depth       = 4
) (
   input  logic                   ACLK,
   input  logic                   ARESETN,
   input  logic                   Wr_Done,
   input  logic [ID_Size-1:0]     Wr_Done_Master,
   input  logic                   Wr_Done_Split,
   input  logic                   S_BVALID,
   input  logic [1:0]             S_BRESP,
   output logic                   S_BREADY,
   output logic [Masters_Num-1:0] M_BVALID,
   output logic [1:0]             M_BRESP,
   input  logic [Masters_Num-1:0] M_BREADY,
   output logic                   Queue_Is_Full,
   output logic                   Queue_Is_Empty,
   output logic                   Overflow
);

   state_t                 state;
   resp_t                  acc;
   resp_t                  m_bresp_q;
   logic [ID_Size-1:0]     cur_master;
   logic [Masters_Num-1:0] m_bvalid_q;
   logic [ID_Size-1:0]     head_master;
   logic                   head_split;
   logic                   s_accept;
   logic [Masters_Num-1:0] head_onehot;

   resp_id_fifo #(
      .Depth   (Depth),
      .ID_Size (ID_Size)
   ) u_fifo (
      .ACLK        (ACLK),
      .ARESETN     (ARESETN),
      .push        (Wr_Done),
      .push_master (Wr_Done_Master),
      .push_split  (Wr_Done_Split),
      .pop         (s_accept),
      .head_master (head_master),
      .head_split  (head_split),
      .full        (Queue_Is_Full),
      .empty       (Queue_Is_Empty),
      .overflow    (Overflow)
   );

   assign S_BREADY = (state == IDLE) && !Queue_Is_Empty;
   assign s_accept = S_BVALID && S_BREADY;
   assign M_BVALID = m_bvalid_q;
   assign M_BRESP  = m_bresp_q;

   // One-hot select of the master owning the head entry.
   always_comb begin
      head_onehot              = '0;
      head_onehot[head_master] = 1'b1;
   end

   // Response FSM: fold split parts into acc, present the merged result to the owning master.
   // acc returns to the neutral code after each delivery so a lone EXOKAY is never demoted.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state      <= IDLE;
         acc        <= ACC_NEUTRAL;
         m_bresp_q  <= OKAY;
         cur_master <= '0;
         m_bvalid_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (s_accept) begin
                  if (head_split) begin
                     acc <= resp_merge(acc, resp_t'(S_BRESP));
                  end else begin
                     m_bresp_q  <= resp_merge(acc, resp_t'(S_BRESP));
                     cur_master <= head_master;
                     m_bvalid_q <= head_onehot;
                     state      <= RESP;
                  end
               end
            end
            RESP: begin
               if (M_BREADY[cur_master]) begin
                  m_bvalid_q <= '0;
                  acc        <= ACC_NEUTRAL;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_b_resp_router.sv
// Directed self-checking bench for b_resp_router (2 masters, depth 4).
module tb_b_resp_router;

   logic       ACLK;
   logic       ARESETN;
   logic       Wr_Done;
   logic [0:0] Wr_Done_Master;
   logic       Wr_Done_Split;
   logic       S_BVALID;
   logic [1:0] S_BRESP;
   logic       S_BREADY;
   logic [1:0] M_BVALID;
   logic [1:0] M_BRESP;
   logic [1:0] M_BREADY;
   logic       Queue_Is_Full;
   logic       Queue_Is_Empty;
   logic       Overflow;

   int checks = 0;
   int passed = 0;

   localparam logic [1:0] R_OKAY   = 2'b00;
   localparam logic [1:0] R_EXOKAY = 2'b01;
   localparam logic [1:0] R_SLVERR = 2'b10;
   localparam logic [1:0] R_DECERR = 2'b11;

   b_resp_router #(
      .Masters_Num (2),
      .ID_Size     (1),
      .Depth       (4)
   ) dut (
      .ACLK           (ACLK),
      .ARESETN        (ARESETN),
      .Wr_Done        (Wr_Done),
      .Wr_Done_Master (Wr_Done_Master),
      .Wr_Done_Split  (Wr_Done_Split),
      .S_BVALID       (S_BVALID),
      .S_BRESP        (S_BRESP),
      .S_BREADY       (S_BREADY),
      .M_BVALID       (M_BVALID),
      .M_BRESP        (M_BRESP),
      .M_BREADY       (M_BREADY),
      .Queue_Is_Full  (Queue_Is_Full),
      .Queue_Is_Empty (Queue_Is_Empty),
      .Overflow       (Overflow)
   );

   // Free-running 10-unit clock.
   initial begin
      ACLK = 1'b0;
      forever #5 ACLK = ~ACLK;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks = checks + 1;
      assert (observed === expected) passed = passed + 1;
      else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
   endtask

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic doReset();
      ARESETN        = 1'b1;
      Wr_Done        = 1'b0;
      Wr_Done_Master = 1'b0;
      Wr_Done_Split  = 1'b0;
      S_BVALID       = 1'b0;
      S_BRESP        = R_OKAY;
      M_BREADY       = 2'b00;
      #1;
      ARESETN = 1'b0;
      repeat (2) tick();
      ARESETN = 1'b1;
      tick();
   endtask

   task automatic applyStimulus(input logic master, input logic split);
      Wr_Done        = 1'b1;
      Wr_Done_Master = master;
      Wr_Done_Split  = split;
      tick();
      Wr_Done        = 1'b0;
      Wr_Done_Split  = 1'b0;
   endtask

   task automatic slaveResp(input logic [1:0] resp);
      S_BVALID = 1'b1;
      S_BRESP  = resp;
      #1;
      checkOutput("s_bready", 32'(S_BREADY), 32'd1);
      tick();
      S_BVALID = 1'b0;
      S_BRESP  = R_OKAY;
   endtask

   task automatic masterAck(input string tag, input logic [1:0] exp_valid, input logic [1:0] exp_resp);
      checkOutput({tag, "_bvalid"}, 32'(M_BVALID), 32'(exp_valid));
      checkOutput({tag, "_bresp"}, 32'(M_BRESP), 32'(exp_resp));
      checkOutput({tag, "_sbready_resp"}, 32'(S_BREADY), 32'd0);
      M_BREADY = exp_valid;
      tick();
      M_BREADY = 2'b00;
      checkOutput({tag, "_bvalid_clr"}, 32'(M_BVALID), 32'd0);
   endtask

   // Directed scenarios run back to back.
   initial begin
      doReset();

      checkOutput("rst_sbready", 32'(S_BREADY), 32'd0);
      checkOutput("rst_mbvalid", 32'(M_BVALID), 32'd0);
      checkOutput("rst_mbresp", 32'(M_BRESP), 32'(R_OKAY));
      checkOutput("rst_full", 32'(Queue_Is_Full), 32'd0);
      checkOutput("rst_empty", 32'(Queue_Is_Empty), 32'd1);
      checkOutput("rst_overflow", 32'(Overflow), 32'd0);

      $display("[TB] single response");
      applyStimulus(1'b1, 1'b0);
      checkOutput("single_empty", 32'(Queue_Is_Empty), 32'd0);
      slaveResp(R_OKAY);
      masterAck("single", 2'b10, R_OKAY);
      checkOutput("single_empty_after", 32'(Queue_Is_Empty), 32'd1);

      $display("[TB] ordering");
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
      slaveResp(R_OKAY);
      masterAck("ord0", 2'b01, R_OKAY);
      slaveResp(R_SLVERR);
      masterAck("ord1", 2'b10, R_SLVERR);
      slaveResp(R_OKAY);
      masterAck("ord2", 2'b01, R_OKAY);
      checkOutput("ord_empty", 32'(Queue_Is_Empty), 32'd1);

      $display("[TB] split merge");
      applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0);
      slaveResp(R_SLVERR);
      checkOutput("split_part_no_bvalid", 32'(M_BVALID), 32'd0);
      slaveResp(R_OKAY);
      masterAck("split", 2'b01, R_SLVERR);
      checkOutput("split_empty", 32'(Queue_Is_Empty), 32'd1);

      doReset();
      applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b1, 1'b0);
      slaveResp(R_EXOKAY);
      checkOutput("exok_part_no_bvalid", 32'(M_BVALID), 32'd0);
      slaveResp(R_EXOKAY);
      masterAck("exok", 2'b10, R_EXOKAY);

      applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0);
      slaveResp(R_OKAY);
      slaveResp(R_EXOKAY);
      masterAck("ok_exok", 2'b01, R_OKAY);

      $display("[TB] full and overflow");
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0);
      checkOutput("full_after3", 32'(Queue_Is_Full), 32'd0);
      applyStimulus(1'b0, 1'b0);
      checkOutput("full_after4", 32'(Queue_Is_Full), 32'd1);
      checkOutput("ovf_after4", 32'(Overflow), 32'd0);
      applyStimulus(1'b1, 1'b0);
      checkOutput("ovf_after5", 32'(Overflow), 32'd1);
      checkOutput("full_after5", 32'(Queue_Is_Full), 32'd1);
      slaveResp(R_OKAY);
      masterAck("drain0", 2'b10, R_OKAY);
      checkOutput("drain_not_full", 32'(Queue_Is_Full), 32'd0);
      slaveResp(R_SLVERR);
      masterAck("drain1", 2'b01, R_SLVERR);
      slaveResp(R_DECERR);
      masterAck("drain2", 2'b10, R_DECERR);
      slaveResp(R_OKAY);
      masterAck("drain3", 2'b01, R_OKAY);
      checkOutput("drain_empty", 32'(Queue_Is_Empty), 32'd1);
      checkOutput("drain_ovf_sticky", 32'(Overflow), 32'd1);

      $display("[TB] backpressure and reset");
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
      slaveResp(R_DECERR);
      M_BREADY = 2'b01;
      for (int i = 0; i < 10; i++) begin
         checkOutput("bp_bvalid", 32'(M_BVALID), 32'b10);
         checkOutput("bp_bresp", 32'(M_BRESP), 32'(R_DECERR));
         checkOutput("bp_sbready", 32'(S_BREADY), 32'd0);
         tick();
      end
      M_BREADY = 2'b00;
      #2;
      ARESETN = 1'b0;
      #1;
      checkOutput("arst_bvalid", 32'(M_BVALID), 32'd0);
      checkOutput("arst_empty", 32'(Queue_Is_Empty), 32'd1);
      checkOutput("arst_overflow", 32'(Overflow), 32'd0);
      tick();
      ARESETN = 1'b1;
      tick();

      $display("[TB] orphan B");
      S_BVALID = 1'b1;
      S_BRESP  = R_SLVERR;
      #1;
      checkOutput("orphan_sbready", 32'(S_BREADY), 32'd0);
      repeat (3) tick();
      checkOutput("orphan_bvalid", 32'(M_BVALID), 32'd0);
      checkOutput("orphan_sbready_late", 32'(S_BREADY), 32'd0);
      S_BVALID = 1'b0;
      tick();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
